ex_muldiv: RTL
==============

# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes the operation code and the two register operands as they leave the ID/EX pipeline register, and it owns the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU as a 33-cycle multicycle operation and executes MTHI/MTLO in one cycle. It raises a stall request when a younger instruction needs the unit or HI/LO while an operation is still in flight.

## Interface

- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input, 1 bit: the single clock; everything is sampled on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `op_valid_i` input, 1 bit: a muldiv-class instruction is in EX this cycle.
- `op_i` input, 3 bits: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- `flush_i` input, 1 bit: the EX instruction is squashed; suppresses acceptance this cycle.
- `hilo_read_i` input, 1 bit: an MFHI/MFLO is in EX this cycle.
- `rs_data_i` input, `WIDTH` bits: first operand (dividend/multiplicand); data source for MTHI/MTLO.
- `rt_data_i` input, `WIDTH` bits: second operand (divisor/multiplier).
- `hi_o` output, `WIDTH` bits: architectural HI.
- `lo_o` output, `WIDTH` bits: architectural LO.
- `busy_o` output, 1 bit: an operation is in flight.
- `stall_o` output, 1 bit: freeze PC, IF/ID and ID/EX; insert a bubble into EX/MEM.

## Operation

- **States:** IDLE, CALC, FIX.
- **Reset:** state IDLE; `hi_o`, `lo_o`, internal accumulators and the counter all 0; `busy_o` and `stall_o` both 0.
- **Acceptance:** an op is accepted only in IDLE, when `op_valid_i` is 1, `flush_i` is 0, and `op_i` is 1 to 6.
  - While `busy_o` is 1, `op_valid_i` is ignored. The pipeline holds the instruction by honouring `stall_o`.
- **MTHI/MTLO:** writes `rs_data_i` into HI or LO at the accepting edge. The state stays IDLE.
- **MULT/MULTU/DIV/DIVU, at the accepting edge:**
  - Latch the operand magnitudes. Signed ops take absolute values; unsigned ops take the raw values.
  - Latch the result signs: quotient/product sign = `rs[31]^rt[31]`, remainder sign = `rs[31]`. Both are 0 for unsigned ops.
  - Clear the counter and go to CALC.
- **CALC:** one radix-2 step per cycle.
  - Multiply: shift-add into a 2×`WIDTH` accumulator.
  - Divide: restoring shift-subtract, producing a `WIDTH`-bit remainder and quotient.
  - After the 32nd step, go to FIX.
- **FIX:** apply the sign correction (two's-complement negate), write HI/LO, go to IDLE.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: HI = remainder, LO = quotient.
- **Divide by zero** (DIV or DIVU): LO = 0xFFFFFFFF, HI = `rs_data_i` as latched. No sign correction is applied.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO = 0x80000000, HI = 0. This is the natural result of the magnitude path; no trap is raised.
- **`flush_i` after acceptance:** no effect. A started operation always commits HI/LO.
- **`busy_o`** = (state ≠ IDLE).
- **`stall_o`** = `busy_o` & (`op_valid_i` | `hilo_read_i`). This is combinational; unrelated instructions keep flowing.

## Timing

- Op accepted at edge 0:
  - CALC for cycles 1–32; FIX in cycle 33.
  - HI/LO are written at edge 33 and hold the new values from cycle 34.
  - `busy_o` is 1 in cycles 1–33.
- MTHI/MTLO accepted at edge 0: the new value is visible from cycle 1.
- An MFHI in cycle 34 reads the new HI without stalling.
- A second MULT presented in cycle 5:
  - `stall_o` is 1 for cycles 5–33.
  - It is accepted at edge 34, at which point `busy_o` is 0.
- `rst_n` low mid-operation (any state): the unit returns to IDLE immediately and HI/LO are cleared.

## Structure

- The op encodings (3-bit `MD_*` constants) live in the shared CPU parameter include, next to the ALUOp encodings. The decoder and the forwarding/hazard logic reuse them.
- One sub-module, `muldiv_step`: a combinational single-iteration datapath (shift-add or shift-subtract, selected by a mode bit).
- The FSM, counter, sign latches and HI/LO registers stay in `ex_muldiv`.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → from cycle 34, HI = 0xFFFFFFFE and LO = 0x00000001; `busy_o` is 1 for exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 ÷ 0 → LO = 0xFFFFFFFF, HI = 100.
- MTLO 0x12345678, then MFLO in the next cycle → `lo_o` = 0x12345678 with `stall_o` = 0.
- MULT at cycle 0, then `hilo_read_i` = 1 at cycle 3 → `stall_o` is 1 during cycles 3–33 and 0 in cycle 34.
- MULT at cycle 0, `rst_n` pulsed low at cycle 10 → `busy_o` = 0 and HI = LO = 0 immediately. A DIVU 9 ÷ 4 afterwards → LO = 2, HI = 1.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states, op-class helper.
package ex_muldiv_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } md_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Multiply: acc = {partial product high, remaining multiplier bits}, opnd = multiplicand.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}, opnd = divisor.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   div_mode_i,
    input  logic [2*WIDTH-1:0]     acc_i,
    input  logic [WIDTH-1:0]       opnd_i,
    output logic [2*WIDTH-1:0]     acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Single iteration; diff[WIDTH] is the borrow of the trial subtraction.
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_i};
        acc_o  = {sum, acc_i[WIDTH-1:1]};
        if (div_mode_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO registers.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid_i,
    input  logic [2:0]       op_i,
    input  logic             flush_i,
    input  logic             hilo_read_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             stall_o
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   raw_rs_q, raw_rs_d;
    logic               is_div_q, is_div_d;
    logic               divz_q, divz_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               op_signed;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] step_acc;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_mode_i (is_div_q),
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (step_acc)
    );

    // Next-state, operand latching, iteration and HI/LO commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        raw_rs_d  = raw_rs_q;
        is_div_d  = is_div_q;
        divz_d    = divz_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod      = '0;

        accept    = (state_q == ST_IDLE) && op_valid_i && !flush_i &&
                    (op_i != MD_NOP) && (op_i != MD_RSVD);
        op_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
        rs_mag    = (op_signed && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
        rt_mag    = (op_signed && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op_i)
                        MD_MTHI: hi_d = rs_data_i;
                        MD_MTLO: lo_d = rs_data_i;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            is_div_d = op_is_div(op_i);
                            // Divide iterates on the dividend, multiply on the multiplier.
                            if (op_is_div(op_i)) begin
                                acc_d  = {{WIDTH{1'b0}}, rs_mag};
                                opnd_d = rt_mag;
                            end else begin
                                acc_d  = {{WIDTH{1'b0}}, rt_mag};
                                opnd_d = rs_mag;
                            end
                            raw_rs_d = rs_data_i;
                            divz_d   = op_is_div(op_i) && (rt_data_i == '0);
                            qsign_d  = op_signed && (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
                            rsign_d  = op_signed && rs_data_i[WIDTH-1];
                            cnt_d    = '0;
                            state_d  = ST_CALC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    if (divz_q) begin
                        hi_d = raw_rs_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                        lo_d = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    end
                end else begin
                    prod = qsign_q ? -acc_q : acc_q;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            raw_rs_q <= '0;
            is_div_q <= 1'b0;
            divz_q   <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            raw_rs_q <= raw_rs_d;
            is_div_q <= is_div_d;
            divz_q   <= divz_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign stall_o = busy_o && (op_valid_i || hilo_read_i);

endmodule
